// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I instruction fetch stage with PC select and IF/ID register
// Holds pc_f, picks the next PC by redirect/stall priority and registers the fetched word.

module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_d_i,
  input  logic [31:0] target_d_i,
  input  logic        redirect_e_i,
  input  logic [31:0] target_e_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_d_o,
  output logic [6:0]  op_d_o,
  output logic [2:0]  func3_d_o,
  output logic [6:0]  func7_d_o,
  output logic [31:0] pc_d_o,
  output logic [31:0] pc_plus4_d_o,
  output logic        valid_d_o
);

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  logic [31:0] pc_f_q,      pc_f_d;
  logic [31:0] dec_instr_q, dec_instr_d;
  logic [31:0] dec_pc_q,    dec_pc_d;
  logic [31:0] dec_pc4_q,   dec_pc4_d;
  logic        dec_valid_q, dec_valid_d;
  logic [31:0] pc_f_plus4;

  assign pc_f_plus4 = pc_f_q + 32'd4;

  // Execute redirect outranks stall: the stalled decode instruction is on the wrong path.
  always_comb begin
    pc_f_d      = pc_f_plus4;
    dec_instr_d = imem_rdata_i;
    dec_pc_d    = pc_f_q;
    dec_pc4_d   = pc_f_plus4;
    dec_valid_d = 1'b1;
    if (redirect_e_i) begin
      pc_f_d      = target_e_i & ALIGN_MASK;
      dec_instr_d = NOP_INSTR;
      dec_pc_d    = dec_pc_q;
      dec_pc4_d   = dec_pc4_q;
      dec_valid_d = 1'b0;
    end else if (stall_i) begin
      pc_f_d      = pc_f_q;
      dec_instr_d = dec_instr_q;
      dec_pc_d    = dec_pc_q;
      dec_pc4_d   = dec_pc4_q;
      dec_valid_d = dec_valid_q;
    end else if (redirect_d_i) begin
      pc_f_d      = target_d_i & ALIGN_MASK;
      dec_instr_d = NOP_INSTR;
      dec_pc_d    = dec_pc_q;
      dec_pc4_d   = dec_pc4_q;
      dec_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_f_q      <= RESET_PC & ALIGN_MASK;
      dec_instr_q <= NOP_INSTR;
      dec_pc_q    <= 32'd0;
      dec_pc4_q   <= 32'd0;
      dec_valid_q <= 1'b0;
    end else begin
      pc_f_q      <= pc_f_d;
      dec_instr_q <= dec_instr_d;
      dec_pc_q    <= dec_pc_d;
      dec_pc4_q   <= dec_pc4_d;
      dec_valid_q <= dec_valid_d;
    end
  end

  assign imem_addr_o  = pc_f_q;
  assign instr_d_o    = dec_instr_q;
  assign op_d_o       = dec_instr_q[6:0];
  assign func3_d_o    = dec_instr_q[14:12];
  assign func7_d_o    = dec_instr_q[31:25];
  assign pc_d_o       = dec_pc_q;
  assign pc_plus4_d_o = dec_pc4_q;
  assign valid_d_o    = dec_valid_q;

endmodule
